// File: rtl/bridge_arbiter.sv
// bridge_arbiter: shares one single-outstanding DRAM bridge command port
// between two requesters. Each requester owns a one-deep pending slot; a
// round-robin FSM issues one slot at a time, waits for the bridge
// completion and returns the result to the owner of that slot.
module bridge_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          rq_valid,
    input  logic [1:0]          rq_r_wb,
    input  logic [2*ADDR_W-1:0] rq_addr,
    input  logic [2*DATA_W-1:0] rq_wdata,
    output logic [1:0]          rq_busy,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                C_in_valid,
    output logic                C_r_wb,
    output logic [ADDR_W-1:0]   C_addr,
    output logic [DATA_W-1:0]   C_data_w,
    input  logic                C_out_valid,
    input  logic [DATA_W-1:0]   C_data_r
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   ptr_q, ptr_d;

    // Pending command slots, one per requester.
    logic [1:0]             slot_full_q, slot_full_d;
    logic [1:0]             slot_r_wb_q, slot_r_wb_d;
    logic [1:0][ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic [1:0][DATA_W-1:0] slot_wdata_q, slot_wdata_d;

    // Command fields presented to the bridge and the captured response.
    logic              c_r_wb_q, c_r_wb_d;
    logic [ADDR_W-1:0] c_addr_q, c_addr_d;
    logic [DATA_W-1:0] c_data_w_q, c_data_w_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    // A slot being retired this cycle is free to take a new command.
    always_comb begin
        rq_busy = slot_full_q;
        if (state_q == S_RESP) begin
            rq_busy[grant_q] = 1'b0;
        end
    end

    // Slot bookkeeping: retire the granted slot in RESP, then accept loads
    // (a load in the same cycle overrides the retire).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        slot_full_d  = slot_full_q;
        slot_r_wb_d  = slot_r_wb_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        for (int i = 0; i < 2; i++) begin
            if (state_q == S_RESP && grant_q == 1'(i)) begin
                slot_full_d[i] = 1'b0;
            end
            if (rq_valid[i] && !rq_busy[i]) begin
                slot_full_d[i]  = 1'b1;
                slot_r_wb_d[i]  = rq_r_wb[i];
                slot_addr_d[i]  = rq_addr[i*ADDR_W +: ADDR_W];
                slot_wdata_d[i] = rq_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Arbitration FSM: next state, grant, bridge fields and pulse outputs.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        c_r_wb_d    = c_r_wb_q;
        c_addr_d    = c_addr_q;
        c_data_w_d  = c_data_w_q;
        rsp_rdata_d = rsp_rdata_q;
        C_in_valid  = 1'b0;
        rsp_valid   = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (|slot_full_q) begin
                    // Both pending: round-robin pointer decides; otherwise the full one.
                    grant_d    = (&slot_full_q) ? ptr_q : ~slot_full_q[0];
                    c_r_wb_d   = slot_r_wb_q[grant_d];
                    c_addr_d   = slot_addr_q[grant_d];
                    c_data_w_d = slot_wdata_q[grant_d];
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                C_in_valid = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (C_out_valid) begin
                    rsp_rdata_d = c_r_wb_q ? C_data_r : '0;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[grant_q] = 1'b1;
                ptr_d              = ~grant_q;
                state_d            = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            ptr_q        <= 1'b0;
            slot_full_q  <= '0;
            // NOTE: slot payloads are only a few flops, so they are reset too; nothing reads them while empty.
            slot_r_wb_q  <= '0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            c_r_wb_q     <= 1'b0;
            c_addr_q     <= '0;
            c_data_w_q   <= '0;
            rsp_rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            slot_full_q  <= slot_full_d;
            slot_r_wb_q  <= slot_r_wb_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            c_r_wb_q     <= c_r_wb_d;
            c_addr_q     <= c_addr_d;
            c_data_w_q   <= c_data_w_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign C_r_wb    = c_r_wb_q;
    assign C_addr    = c_addr_q;
    assign C_data_w  = c_data_w_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Testbench for bridge_arbiter: a timestamp-based transaction model predicts
// every output on every cycle; directed scenarios pin the model with literal
// expectations, then a randomized phase exercises arbitration, drops,
// stray completions and resets.
module tb_bridge_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      rq_valid;
    logic [1:0]      rq_r_wb;
    logic [2*AW-1:0] rq_addr;
    logic [2*DW-1:0] rq_wdata;
    logic [1:0]      rq_busy;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            C_in_valid;
    logic            C_r_wb;
    logic [AW-1:0]   C_addr;
    logic [DW-1:0]   C_data_w;
    logic            C_out_valid;
    logic [DW-1:0]   C_data_r;

    bridge_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .rq_valid(rq_valid), .rq_r_wb(rq_r_wb), .rq_addr(rq_addr), .rq_wdata(rq_wdata),
        .rq_busy(rq_busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
        .C_out_valid(C_out_valid), .C_data_r(C_data_r)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp_v);
        end
    endtask

    // ---------------- behavioural model (transaction timestamps) ----------------
    bit [1:0]      m_full;
    bit [1:0]      m_rwb;
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wdata [2];
    bit            m_ptr;
    bit            m_txn;        // a transaction is in flight
    bit            m_g;          // requester it belongs to
    int            m_t_issue;    // cycle the command pulse is due
    int            m_t_resp;     // cycle the response pulse is due (-1 unknown)
    bit            e_rwb;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [DW-1:0] e_rdata;

    task automatic model_reset();
        m_full = 2'b00; m_rwb = 2'b00; m_ptr = 1'b0; m_txn = 1'b0; m_g = 1'b0;
        m_t_issue = -1; m_t_resp = -1;
        e_rwb = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    endtask

    task automatic model_update(input bit [1:0] busy, input bit in_resp);
        bit [1:0] pre_full = m_full;
        bit       was_txn  = m_txn;
        if (m_txn && m_t_resp < 0 && cyc > m_t_issue && C_out_valid) begin
            m_t_resp = cyc + 1;
            e_rdata  = e_rwb ? C_data_r : '0;
        end
        if (in_resp) begin
            m_full[m_g] = 1'b0;
            m_ptr       = !m_g;
            m_txn       = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (rq_valid[i] && !busy[i]) begin
                m_full[i]  = 1'b1;
                m_rwb[i]   = rq_r_wb[i];
                m_addr[i]  = rq_addr[i*AW +: AW];
                m_wdata[i] = rq_wdata[i*DW +: DW];
            end
        end
        if (!was_txn && pre_full != 2'b00) begin
            m_g       = (pre_full == 2'b11) ? m_ptr : (pre_full[0] ? 1'b0 : 1'b1);
            m_txn     = 1'b1;
            m_t_issue = cyc + 1;
            m_t_resp  = -1;
            e_rwb     = m_rwb[m_g];
            e_addr    = m_addr[m_g];
            e_wdata   = m_wdata[m_g];
        end
    endtask

    // ---------------- stimulus controls, bridge responder, event logs ----------------
    bit [1:0]      nx_rq_valid;
    bit [1:0]      nx_r_wb;
    logic [AW-1:0] nx_addr [2];
    logic [DW-1:0] nx_wdata [2];
    bit            nx_stray;
    logic [DW-1:0] nx_stray_data;
    bit            nx_rst;
    bit            repulse;

    int            br_resp_at = -1;
    int            br_delay   = 3;
    bit            br_random  = 1'b0;
    logic [DW-1:0] br_data;

    int            iss_cyc_q [$];
    logic [AW-1:0] iss_addr_q [$];
    bit            iss_rwb_q [$];
    logic [DW-1:0] iss_wd_q [$];
    int            rsp_cyc_q [$];
    logic [1:0]    rsp_vec_q [$];
    logic [DW-1:0] rsp_dat_q [$];
    int            cout_cyc_q [$];

    task automatic clear_logs();
        iss_cyc_q.delete(); iss_addr_q.delete(); iss_rwb_q.delete(); iss_wd_q.delete();
        rsp_cyc_q.delete(); rsp_vec_q.delete(); rsp_dat_q.delete(); cout_cyc_q.delete();
    endtask

    // One clock cycle: compare all outputs against the model, log events,
    // drive this cycle's inputs, then advance the model across the next edge.
    task automatic step();
        bit       in_resp;
        bit [1:0] e_busy;
        bit [1:0] e_rspv;
        @(negedge clk);
        in_resp = m_txn && (m_t_resp == cyc);
        e_busy  = m_full;
        if (in_resp) e_busy[m_g] = 1'b0;
        e_rspv  = in_resp ? (m_g ? 2'b10 : 2'b01) : 2'b00;
        check("rq_busy",    rq_busy,    e_busy);
        check("rsp_valid",  rsp_valid,  e_rspv);
        check("rsp_rdata",  rsp_rdata,  e_rdata);
        check("C_in_valid", C_in_valid, m_txn && (cyc == m_t_issue));
        check("C_r_wb",     C_r_wb,     e_rwb);
        check("C_addr",     C_addr,     e_addr);
        check("C_data_w",   C_data_w,   e_wdata);

        if (C_in_valid === 1'b1) begin
            iss_cyc_q.push_back(cyc); iss_addr_q.push_back(C_addr);
            iss_rwb_q.push_back(C_r_wb); iss_wd_q.push_back(C_data_w);
            br_resp_at = cyc + br_delay;
            if (br_random) br_data = $urandom;
        end
        if (rsp_valid !== 2'b00) begin
            rsp_cyc_q.push_back(cyc); rsp_vec_q.push_back(rsp_valid); rsp_dat_q.push_back(rsp_rdata);
            if (repulse) nx_rq_valid = 2'b11;
        end

        rst      = nx_rst;
        rq_valid = nx_rq_valid;
        rq_r_wb  = nx_r_wb;
        rq_addr  = {nx_addr[1], nx_addr[0]};
        rq_wdata = {nx_wdata[1], nx_wdata[0]};
        if (cyc == br_resp_at) begin
            C_out_valid = 1'b1; C_data_r = br_data; cout_cyc_q.push_back(cyc);
        end else if (nx_stray) begin
            C_out_valid = 1'b1; C_data_r = nx_stray_data;
        end else begin
            C_out_valid = 1'b0; C_data_r = $urandom;
        end

        if (rst) model_reset();
        else     model_update(e_busy, in_resp);
        cyc++;

        nx_rq_valid = 2'b00;
        nx_stray    = 1'b0;
        nx_r_wb     = 2'($urandom);
        for (int i = 0; i < 2; i++) begin
            nx_addr[i]  = 8'($urandom);
            nx_wdata[i] = $urandom;
        end
    endtask

    task automatic run_until_idle(input int max_cycles, input string name);
        int k = 0;
        bit idle;
        do begin
            step();
            k++;
            idle = !m_txn && (m_full == 2'b00) && (br_resp_at < cyc);
        end while (!idle && k < max_cycles);
        check({name, "_reached_idle"}, idle, 1'b1);
        step();
        step();
    endtask

    task automatic do_reset(input int n);
        nx_rst = 1'b1;
        for (int k = 0; k < n; k++) step();
        nx_rst = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int rel_cyc;
        int k;
        rst = 1'b1; rq_valid = '0; rq_r_wb = '0; rq_addr = '0; rq_wdata = '0;
        C_out_valid = 1'b0; C_data_r = '0;
        nx_rq_valid = '0; nx_r_wb = '0; nx_stray = 1'b0; nx_stray_data = '0; repulse = 1'b0;
        for (int i = 0; i < 2; i++) begin nx_addr[i] = '0; nx_wdata[i] = '0; end
        nx_rst = 1'b1;
        model_reset();
        step();
        step();
        nx_rst = 1'b0;
        step();

        // 1: single read from requester 0
        clear_logs();
        br_random = 1'b0; br_delay = 3; br_data = 32'hDEADBEEF;
        t0 = cyc;
        nx_rq_valid = 2'b01; nx_r_wb = 2'b01; nx_addr[0] = 8'h12;
        step();
        run_until_idle(30, "t1");
        check("t1_issue_count", iss_cyc_q.size(), 1);
        if (iss_cyc_q.size() > 0) begin
            check("t1_issue_cycle", iss_cyc_q[0], t0 + 2);
            check("t1_issue_addr", iss_addr_q[0], 8'h12);
            check("t1_issue_rwb", iss_rwb_q[0], 1'b1);
        end
        check("t1_rsp_count", rsp_cyc_q.size(), 1);
        if (rsp_cyc_q.size() > 0 && cout_cyc_q.size() > 0) begin
            check("t1_rsp_vec", rsp_vec_q[0], 2'b01);
            check("t1_rsp_data", rsp_dat_q[0], 32'hDEADBEEF);
            check("t1_rsp_latency", rsp_cyc_q[0], cout_cyc_q[0] + 1);
        end

        // 2: simultaneous requests with ptr = 0
        do_reset(2);
        clear_logs();
        br_delay = 2; br_data = 32'h55AA55AA;
        nx_rq_valid = 2'b11; nx_r_wb = 2'b01;
        nx_addr[0] = 8'h05; nx_addr[1] = 8'h07; nx_wdata[1] = 32'h0000_00AB;
        step();
        run_until_idle(40, "t2");
        check("t2_issue_count", iss_cyc_q.size(), 2);
        check("t2_rsp_count", rsp_cyc_q.size(), 2);
        if (iss_cyc_q.size() > 1 && rsp_cyc_q.size() > 1) begin
            check("t2_first_addr", iss_addr_q[0], 8'h05);
            check("t2_first_rwb", iss_rwb_q[0], 1'b1);
            check("t2_second_addr", iss_addr_q[1], 8'h07);
            check("t2_second_rwb", iss_rwb_q[1], 1'b0);
            check("t2_second_wdata", iss_wd_q[1], 32'h0000_00AB);
            check("t2_first_vec", rsp_vec_q[0], 2'b01);
            check("t2_first_data", rsp_dat_q[0], 32'h55AA55AA);
            check("t2_second_vec", rsp_vec_q[1], 2'b10);
            check("t2_second_data", rsp_dat_q[1], 32'h0);
        end

        // 3: both requesters re-pulse in every response cycle
        clear_logs();
        br_random = 1'b1; br_delay = 1; repulse = 1'b1;
        nx_rq_valid = 2'b11;
        step();
        k = 0;
        while (rsp_vec_q.size() < 6 && k < 120) begin step(); k++; end
        repulse = 1'b0;
        check("t3_six_responses", rsp_vec_q.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i < rsp_vec_q.size()) check("t3_grant_order", rsp_vec_q[i], (i % 2) ? 2'b10 : 2'b01);
        end
        run_until_idle(60, "t3");

        // 4: second pulse while busy is dropped
        clear_logs();
        br_random = 1'b0; br_delay = 4; br_data = 32'h600D_0001;
        nx_rq_valid = 2'b10; nx_r_wb = 2'b00; nx_addr[1] = 8'h20;
        step();
        nx_rq_valid = 2'b10; nx_r_wb = 2'b00; nx_addr[1] = 8'h21;
        step();
        run_until_idle(30, "t4");
        check("t4_issue_count", iss_cyc_q.size(), 1);
        if (iss_cyc_q.size() > 0) check("t4_issue_addr", iss_addr_q[0], 8'h20);
        check("t4_rsp_count", rsp_cyc_q.size(), 1);
        if (rsp_cyc_q.size() > 0) check("t4_rsp_vec", rsp_vec_q[0], 2'b10);

        // 5: reset during WAIT, late completion afterwards is ignored
        clear_logs();
        br_delay = 6; br_data = 32'h0BAD_F00D;
        nx_rq_valid = 2'b01; nx_r_wb = 2'b01; nx_addr[0] = 8'h33;
        step();
        k = 0;
        while (iss_cyc_q.size() == 0 && k < 10) begin step(); k++; end
        check("t5_issued", iss_cyc_q.size(), 1);
        step();
        nx_rst = 1'b1;
        step();
        step();
        nx_rst = 1'b0;
        rel_cyc = cyc;
        step();
        for (int i = 0; i < 6; i++) step();
        check("t5_no_rsp", rsp_cyc_q.size(), 0);
        check("t5_cout_seen", cout_cyc_q.size(), 1);
        if (cout_cyc_q.size() > 0) check("t5_cout_after_release", cout_cyc_q[0] > rel_cyc, 1'b1);
        check("t5_rdata_cleared", rsp_rdata, 32'h0);
        clear_logs();
        br_delay = 2; br_data = 32'hCAFE_F00D;
        nx_rq_valid = 2'b01; nx_r_wb = 2'b01; nx_addr[0] = 8'h44;
        step();
        run_until_idle(30, "t5b");
        check("t5b_rsp_count", rsp_cyc_q.size(), 1);
        if (rsp_cyc_q.size() > 0) begin
            check("t5b_rsp_vec", rsp_vec_q[0], 2'b01);
            check("t5b_rsp_data", rsp_dat_q[0], 32'hCAFE_F00D);
        end

        // 6: stray completion in IDLE
        clear_logs();
        nx_stray = 1'b1; nx_stray_data = 32'h1234_5678;
        step();
        for (int i = 0; i < 3; i++) step();
        check("t6_no_rsp", rsp_cyc_q.size(), 0);
        check("t6_rdata_held", rsp_rdata, 32'hCAFE_F00D);

        // Randomized traffic
        clear_logs();
        br_random = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            nx_rq_valid[0] = ($urandom_range(0, 9) < 3);
            nx_rq_valid[1] = ($urandom_range(0, 9) < 3);
            br_delay       = $urandom_range(1, 5);
            if ($urandom_range(0, 19) == 0) begin
                nx_stray = 1'b1; nx_stray_data = $urandom;
            end
            nx_rst = ($urandom_range(0, 499) == 0);
            step();
        end
        nx_rst = 1'b0;
        run_until_idle(60, "rand");
        check("rand_traffic_seen", rsp_cyc_q.size() > 50, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
